// File: rtl/slot_round_controller.sv
// slot_round_controller
//
// Sequences one play round of the slot game. A rising edge on spin_btn in IDLE
// starts all reels, which run for SPIN_TICKS ticks. They are then stopped one at a
// time, reel 0 first, every STOP_GAP_TICKS ticks. After the last reel stops, two
// settle cycles cover the win checker latency. On a win, buzz_en is held for
// BUZZ_TICKS ticks. Every round ends with a one-cycle stop pulse on the first
// IDLE cycle. A tick is one cycle in every TICK_DIV cycles of the internal
// prescaler.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous reset, active high
//   spin_btn   in   debounced, synchronised spin request (level)
//   win        in   win checker result (registered in the checker)
//   reel_run   out  per-reel run enable, 1 = spinning
//   stop       out  one-cycle clear pulse to the win checker at round end
//   buzz_en    out  buzzer enable
//   busy       out  high whenever the controller is not idle
//   win_count  out  wins since reset, saturating at 255

module slot_round_controller #(
  parameter int unsigned NUM_REELS      = 8,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned SPIN_TICKS     = 200,
  parameter int unsigned STOP_GAP_TICKS = 50,
  parameter int unsigned BUZZ_TICKS     = 500
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spin_btn,
  input  logic                 win,
  output logic [NUM_REELS-1:0] reel_run,
  output logic                 stop,
  output logic                 buzz_en,
  output logic                 busy,
  output logic [7:0]           win_count
);

  localparam int unsigned PresW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MaxSpGap = (SPIN_TICKS > STOP_GAP_TICKS) ? SPIN_TICKS
                                                                   : STOP_GAP_TICKS;
  localparam int unsigned MaxTicks = (MaxSpGap > BUZZ_TICKS) ? MaxSpGap : BUZZ_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam int unsigned IdxW     = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSpin,
    StStopping,
    StSettle,
    StWin
  } state_e;

  // State and datapath registers
  state_e               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [IdxW-1:0]      r_idx;
  logic [PresW-1:0]     r_presc;
  logic [7:0]           r_win_count;
  logic                 r_spin_btn_q;
  logic [NUM_REELS-1:0] r_reel_run;
  logic                 r_stop;
  logic                 r_buzz_en;

  // Next-state values
  state_e               w_state_next;
  logic [CntW-1:0]      w_cnt_next;
  logic [IdxW-1:0]      w_idx_next;
  logic [PresW-1:0]     w_presc_next;
  logic [7:0]           w_win_count_next;
  logic [NUM_REELS-1:0] w_reel_run_next;
  logic                 w_stop_next;
  logic                 w_buzz_en_next;

  // Decoded events
  logic                 w_start;
  logic                 w_tick;
  logic                 w_cnt_last;
  logic                 w_settle_done;
  logic                 w_last_reel;
  logic [PresW-1:0]     w_presc_inc;

  assign w_start       = (r_state == StIdle) && spin_btn && !r_spin_btn_q;
  assign w_tick        = (r_presc == PresW'(TICK_DIV - 1));
  // The tick that takes the counter from 1 to 0 ends the current phase.
  assign w_cnt_last    = (r_cnt == CntW'(1));
  assign w_settle_done = (r_cnt == '0);
  assign w_last_reel   = (r_idx == IdxW'(NUM_REELS - 1));
  assign w_presc_inc   = w_tick ? '0 : (r_presc + PresW'(1));

  // ---------------------------------------------------------------------------
  // State register (also holds the datapath registers and registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_presc      <= '0;
      r_win_count  <= '0;
      r_spin_btn_q <= 1'b0;
      r_reel_run   <= '0;
      r_stop       <= 1'b0;
      r_buzz_en    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_presc      <= w_presc_next;
      r_win_count  <= w_win_count_next;
      r_spin_btn_q <= spin_btn;
      r_reel_run   <= w_reel_run_next;
      r_stop       <= w_stop_next;
      r_buzz_en    <= w_buzz_en_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_idx_next       = r_idx;
    w_presc_next     = r_presc;
    w_win_count_next = r_win_count;

    unique case (r_state)
      StIdle: begin
        // Prescaler frozen at 0 so the first spin tick lands TICK_DIV cycles in.
        w_presc_next = '0;
        if (w_start) begin
          w_state_next = StSpin;
          w_cnt_next   = CntW'(SPIN_TICKS);
          w_idx_next   = '0;
        end
      end

      StSpin: begin
        w_presc_next = w_presc_inc;
        if (w_tick) begin
          if (w_cnt_last) begin
            w_state_next = StStopping;
            w_cnt_next   = CntW'(STOP_GAP_TICKS);
            w_idx_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CntW'(1);
          end
        end
      end

      StStopping: begin
        w_presc_next = w_presc_inc;
        if (w_tick) begin
          if (w_cnt_last) begin
            if (w_last_reel) begin
              // Two settle cycles: counter runs 1, 0 and the decision is taken at 0.
              w_state_next = StSettle;
              w_cnt_next   = CntW'(1);
            end else begin
              w_idx_next = r_idx + IdxW'(1);
              w_cnt_next = CntW'(STOP_GAP_TICKS);
            end
          end else begin
            w_cnt_next = r_cnt - CntW'(1);
          end
        end
      end

      StSettle: begin
        // Restart the prescaler so the buzz window is exactly BUZZ_TICKS ticks.
        w_presc_next = '0;
        if (w_settle_done) begin
          if (win) begin
            w_state_next = StWin;
            w_cnt_next   = CntW'(BUZZ_TICKS);
            if (r_win_count != 8'hFF) begin
              w_win_count_next = r_win_count + 8'd1;
            end
          end else begin
            w_state_next = StIdle;
          end
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end

      StWin: begin
        w_presc_next = w_presc_inc;
        if (w_tick) begin
          if (w_cnt_last) begin
            w_state_next = StIdle;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CntW'(1);
          end
        end
      end

      default: begin
        w_state_next = StIdle;
        w_presc_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_reel_run_next = r_reel_run;
    w_stop_next     = 1'b0;
    w_buzz_en_next  = r_buzz_en;

    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_reel_run_next = '1;
        end
      end

      StSpin: begin
      end

      StStopping: begin
        if (w_tick && w_cnt_last) begin
          w_reel_run_next[r_idx] = 1'b0;
        end
      end

      StSettle: begin
        if (w_settle_done) begin
          if (win) begin
            w_buzz_en_next = 1'b1;
          end else begin
            w_stop_next = 1'b1;
          end
        end
      end

      StWin: begin
        if (w_tick && w_cnt_last) begin
          w_buzz_en_next = 1'b0;
          w_stop_next    = 1'b1;
        end
      end

      default: begin
        w_reel_run_next = '0;
        w_buzz_en_next  = 1'b0;
      end
    endcase
  end

  assign reel_run  = r_reel_run;
  assign stop      = r_stop;
  assign buzz_en   = r_buzz_en;
  assign busy      = (r_state != StIdle);
  assign win_count = r_win_count;

endmodule

// File: tb/tb_slot_round_controller.sv
// Scoreboard bench for slot_round_controller with NUM_REELS=4, TICK_DIV=2,
// SPIN_TICKS=3, STOP_GAP_TICKS=1, BUZZ_TICKS=2. The stimulus pushes the
// hand-derived expected outputs for each cycle; the monitor compares at negedge.

module tb_slot_round_controller;

  logic       clk;
  logic       reset;
  logic       spin_btn;
  logic       win;
  logic [3:0] reel_run;
  logic       stop;
  logic       buzz_en;
  logic       busy;
  logic [7:0] win_count;

  slot_round_controller #(
    .NUM_REELS     (4),
    .TICK_DIV      (2),
    .SPIN_TICKS    (3),
    .STOP_GAP_TICKS(1),
    .BUZZ_TICKS    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spin_btn (spin_btn),
    .win      (win),
    .reel_run (reel_run),
    .stop     (stop),
    .buzz_en  (buzz_en),
    .busy     (busy),
    .win_count(win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          k;
    int          id;
    logic [3:0]  rr;
    logic        stop;
    logic        buzz;
    logic        busy;
    logic [7:0]  wc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL missed test%0d k=%0d: expectation for cycle %0d not checked (now %0d)",
                 e.id, e.k, e.cyc, cyc);
      end else if (reel_run !== e.rr || stop !== e.stop || buzz_en !== e.buzz ||
                   busy !== e.busy || win_count !== e.wc) begin
        errors++;
        $display("FAIL test%0d k=%0d: got rr=%b stop=%b buzz=%b busy=%b wc=%0d, want rr=%b stop=%b buzz=%b busy=%b wc=%0d",
                 e.id, e.k, reel_run, stop, buzz_en, busy, win_count,
                 e.rr, e.stop, e.buzz, e.busy, e.wc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) step();
  endtask

  // Expected reel_run k cycles after the start edge, from the losing-round trace.
  function automatic logic [3:0] exp_rr(input int k);
    if (k >= 1 && k <= 8)        return 4'b1111;
    else if (k >= 9 && k <= 10)  return 4'b1110;
    else if (k >= 11 && k <= 12) return 4'b1100;
    else if (k >= 13 && k <= 14) return 4'b1000;
    else                         return 4'b0000;
  endfunction

  task automatic push_round(input int unsigned base, input bit won, input int k0,
                            input int k1, input int id, input logic [7:0] wc0,
                            input logic [7:0] wc1);
    for (int k = k0; k <= k1; k++) begin
      exp_t e;
      e.cyc  = base + int'(k);
      e.k    = k;
      e.id   = id;
      e.rr   = exp_rr(k);
      e.busy = (k >= 1) && (k <= (won ? 20 : 16));
      e.stop = (k == (won ? 21 : 17));
      e.buzz = won && (k >= 17) && (k <= 20);
      e.wc   = (won && k >= 17) ? wc1 : wc0;
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input int unsigned c, input logic [7:0] wc, input int id);
    exp_t e;
    e.cyc  = c;
    e.k    = -1;
    e.id   = id;
    e.rr   = 4'b0000;
    e.stop = 1'b0;
    e.buzz = 1'b0;
    e.busy = 1'b0;
    e.wc   = wc;
    sb.push_back(e);
  endtask

  initial begin
    int unsigned base;
    int unsigned base2;
    logic [7:0]  wc0;
    logic [7:0]  wc1;

    reset    = 1'b1;
    spin_btn = 1'b0;
    win      = 1'b0;

    // Test 0: reset state
    step();
    push_idle(cyc, 8'd0, 0);
    step();
    push_idle(cyc, 8'd0, 0);
    reset = 1'b0;
    step();
    push_idle(cyc, 8'd0, 0);
    step();

    // Test 1: losing round
    base = cyc;
    spin_btn = 1'b1;
    push_round(base, 1'b0, 0, 17, 1, 8'd0, 8'd0);
    step();
    spin_btn = 1'b0;
    wait_cyc(base + 18);

    // Test 2: winning round
    base = cyc;
    spin_btn = 1'b1;
    push_round(base, 1'b1, 0, 22, 2, 8'd0, 8'd1);
    step();
    spin_btn = 1'b0;
    wait_cyc(base + 15);
    win = 1'b1;
    wait_cyc(base + 22);
    win = 1'b0;
    step();

    // Test 3: ignored spin pulses, then a restart in the stop cycle
    base = cyc;
    spin_btn = 1'b1;
    push_round(base, 1'b0, 0, 17, 3, 8'd1, 8'd1);
    step();
    spin_btn = 1'b0;
    wait_cyc(base + 5);
    spin_btn = 1'b1;
    step();
    spin_btn = 1'b0;
    wait_cyc(base + 12);
    spin_btn = 1'b1;
    step();
    spin_btn = 1'b0;
    wait_cyc(base + 17);
    base2 = cyc;
    spin_btn = 1'b1;
    push_round(base2, 1'b0, 1, 18, 4, 8'd1, 8'd1);
    step();
    spin_btn = 1'b0;
    wait_cyc(base2 + 19);

    // Test 5: asynchronous reset mid-round, no stop pulse, no restart without an edge
    base = cyc;
    spin_btn = 1'b1;
    push_round(base, 1'b0, 0, 9, 5, 8'd1, 8'd1);
    step();
    spin_btn = 1'b0;
    wait_cyc(base + 10);
    #2;
    reset = 1'b1;
    for (int i = 10; i <= 20; i++) push_idle(base + i, 8'd0, 6);
    wait_cyc(base + 12);
    #2;
    reset = 1'b0;
    wait_cyc(base + 21);

    // Test 7: 256 winning rounds with spin_btn held high through each round
    win = 1'b1;
    for (int r = 1; r <= 256; r++) begin
      base = cyc;
      spin_btn = 1'b1;
      wc0 = 8'(r - 1);
      wc1 = (r > 255) ? 8'd255 : 8'(r);
      push_round(base, 1'b1, 0, 22, 7, wc0, wc1);
      wait_cyc(base + 22);
      spin_btn = 1'b0;
      step();
    end
    win = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
